// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - start/parity/stop/break check of received UART frames with one-entry output register
module uart_rx_frame_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frm_valid,
    input  logic [DATA_W-1:0] frm_data,
    input  logic              frm_start,
    input  logic              frm_parity,
    input  logic [1:0]        frm_stop,
    input  logic [4:0]        cfg_data_bits,
    input  logic [2:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  parity_cnt,
    output logic [CNT_W-1:0]  framing_cnt,
    input  logic              clr_stats
);

    localparam logic [2:0]       PAR_ODD   = 3'b001;
    localparam logic [2:0]       PAR_EVEN  = 3'b010;
    localparam logic [2:0]       PAR_MARK  = 3'b011;
    localparam logic [2:0]       PAR_SPACE = 3'b100;
    localparam logic [5:0]       MAX_LEN   = 6'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Output holding register and statistics
    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] out_data_q,    out_data_d;
    logic [3:0]        out_err_q,     out_err_d;
    logic              overrun_q,     overrun_d;
    logic [CNT_W-1:0]  parity_cnt_q,  parity_cnt_d;
    logic [CNT_W-1:0]  framing_cnt_q, framing_cnt_d;

    // Frame check datapath
    logic [5:0]        cfg_len;
    logic [5:0]        eff_len;
    logic [DATA_W-1:0] data_mask;
    logic [DATA_W-1:0] data_masked;
    logic              data_xor;
    logic              par_en;
    logic              par_err;
    logic              start_err;
    logic              stop_err;
    logic              brk;
    logic [3:0]        frm_err;

    // Handshake
    logic              load;
    logic              drop;

    // Counter bases after an optional clear
    logic [CNT_W-1:0]  par_base;
    logic [CNT_W-1:0]  frm_base;

    assign cfg_len = {1'b0, cfg_data_bits};

    // Out-of-range lengths fall back to the full data width
    always_comb begin
        eff_len = MAX_LEN;
        if ((cfg_len >= 6'd5) && (cfg_len <= MAX_LEN)) begin
            eff_len = cfg_len;
        end
    end

    // Build the mask of active data bits [eff_len-1:0]
    always_comb begin
        data_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_mask[i] = (6'(i) < eff_len);
        end
    end

    assign data_masked = frm_data & data_mask;
    assign data_xor    = ^data_masked;

    // Parity check per configured mode; reserved codes behave as no parity
    always_comb begin
        par_en  = 1'b1;
        par_err = 1'b0;
        case (cfg_parity)
            PAR_ODD:   par_err = ~(data_xor ^ frm_parity);
            PAR_EVEN:  par_err = data_xor ^ frm_parity;
            PAR_MARK:  par_err = ~frm_parity;
            PAR_SPACE: par_err = frm_parity;
            default:   par_en  = 1'b0;
        endcase
    end

    // Start, stop and break detection; a break always implies a framing error
    always_comb begin
        start_err = frm_start;
        stop_err  = ~frm_stop[0] | (cfg_stop2 & ~frm_stop[1]);
        brk       = (data_masked == '0) & ~frm_start & ~frm_stop[0] &
                    (~par_en | ~frm_parity);
        frm_err   = {brk, stop_err | brk, start_err, par_err};
    end

    assign load = frm_valid & (~out_valid_q | out_ready);
    assign drop = frm_valid & out_valid_q & ~out_ready;

    // Output register: load a checked frame, or release it when consumed
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = data_masked;
            out_err_d   = frm_err;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Statistics: clear applies first, then this cycle's event is accounted on top
    always_comb begin
        par_base      = clr_stats ? '0 : parity_cnt_q;
        frm_base      = clr_stats ? '0 : framing_cnt_q;
        parity_cnt_d  = par_base;
        framing_cnt_d = frm_base;
        if (load && frm_err[0] && (par_base != CNT_MAX)) begin
            parity_cnt_d = par_base + CNT_W'(1);
        end
        if (load && (frm_err[1] || frm_err[2]) && (frm_base != CNT_MAX)) begin
            framing_cnt_d = frm_base + CNT_W'(1);
        end
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_stats) begin
            overrun_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_q     <= '0;
            overrun_q     <= 1'b0;
            parity_cnt_q  <= '0;
            framing_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            overrun_q     <= overrun_d;
            parity_cnt_q  <= parity_cnt_d;
            framing_cnt_q <= framing_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign overrun     = overrun_q;
    assign parity_cnt  = parity_cnt_q;
    assign framing_cnt = framing_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - scoreboard bench for uart_rx_frame_check
module tb_uart_rx_frame_check;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frm_valid;
    logic [DW-1:0] frm_data;
    logic          frm_start;
    logic          frm_parity;
    logic [1:0]    frm_stop;
    logic [4:0]    cfg_data_bits;
    logic [2:0]    cfg_parity;
    logic          cfg_stop2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_err;
    logic          overrun;
    logic [CW-1:0] parity_cnt;
    logic [CW-1:0] framing_cnt;
    logic          clr_stats;

    uart_rx_frame_check #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frm_valid    (frm_valid),
        .frm_data     (frm_data),
        .frm_start    (frm_start),
        .frm_parity   (frm_parity),
        .frm_stop     (frm_stop),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .overrun      (overrun),
        .parity_cnt   (parity_cnt),
        .framing_cnt  (framing_cnt),
        .clr_stats    (clr_stats)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard of loaded frames {err[3:0], data[7:0]} and reference state
    logic [11:0]   sb_q[$];
    logic [11:0]   cur;
    bit            mv    = 0;
    logic [CW-1:0] m_pc  = '0;
    logic [CW-1:0] m_fc  = '0;
    bit            m_ovr = 0;

    function automatic logic [11:0] model_frame(logic [7:0] d, logic st, logic par,
                                                logic [1:0] sp, logic [4:0] nb,
                                                logic [2:0] pm, logic s2);
        int         len;
        logic [7:0] m;
        logic       p, pe, pen, brk, se;
        len = (int'(nb) >= 5 && int'(nb) <= 8) ? int'(nb) : 8;
        m = 8'h00;
        for (int i = 0; i < len; i++) m[i] = d[i];
        p   = ^m;
        pen = 1'b1;
        case (pm)
            3'd1:    pe = ~(p ^ par);
            3'd2:    pe = p ^ par;
            3'd3:    pe = ~par;
            3'd4:    pe = par;
            default: begin pe = 1'b0; pen = 1'b0; end
        endcase
        brk = (m == 8'h00) && !st && !sp[0] && (!pen || !par);
        se  = !sp[0] || (s2 && !sp[1]) || brk;
        return {brk, se, st, pe, m};
    endfunction

    function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + 1'b1;
    endfunction

    // Advance one clock, updating the reference from the inputs applied this cycle
    task automatic step();
        logic [11:0] e;
        bit ld, ov;
        ld = frm_valid && (!mv || out_ready);
        ov = frm_valid && mv && !out_ready;
        e  = model_frame(frm_data, frm_start, frm_parity, frm_stop,
                         cfg_data_bits, cfg_parity, cfg_stop2);
        if (clr_stats) begin m_pc = '0; m_fc = '0; end
        if (ov) m_ovr = 1;
        else if (clr_stats) m_ovr = 0;
        if (ld) begin
            sb_q.push_back(e);
            mv = 1;
            if (e[8]) m_pc = sat_inc(m_pc);
            if (e[9] || e[10]) m_fc = sat_inc(m_fc);
        end else if (mv && out_ready) begin
            mv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(logic [7:0] d, logic st, logic par, logic [1:0] sp);
        frm_data   = d;
        frm_start  = st;
        frm_parity = par;
        frm_stop   = sp;
        frm_valid  = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frm_valid = 0; frm_data = '0; frm_start = 0; frm_parity = 0;
        frm_stop = 2'b11; cfg_data_bits = 5'd8; cfg_parity = 3'd0; cfg_stop2 = 0;
        out_ready = 0; clr_stats = 0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", out_valid); bad++; end
        total++; if (out_data !== 8'h00 || out_err !== 4'h0) begin $display("FAIL reset_frame: got %h/%b want 00/0000", out_data, out_err); bad++; end
        total++; if (overrun !== 1'b0 || parity_cnt !== '0 || framing_cnt !== '0) begin $display("FAIL reset_stats: got ovr=%b pc=%0d fc=%0d want 0/0/0", overrun, parity_cnt, framing_cnt); bad++; end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_even_parity();
        cfg_data_bits = 5'd8; cfg_parity = 3'b010; cfg_stop2 = 0; out_ready = 0;
        set_frame(8'hA5, 0, 0, 2'b01); step(); frm_valid = 0;
        cur = sb_q.pop_front();
        total++; if (out_valid !== 1'b1) begin $display("FAIL even_valid: got %b want 1", out_valid); bad++; end
        total++; if ({out_err, out_data} !== cur) begin $display("FAIL even_frame: got %b/%h want %b/%h", out_err, out_data, cur[11:8], cur[7:0]); bad++; end
        total++; if (parity_cnt !== m_pc || framing_cnt !== m_fc) begin $display("FAIL even_cnt: got %0d/%0d want %0d/%0d", parity_cnt, framing_cnt, m_pc, m_fc); bad++; end
        drain();
        total++; if (out_valid !== 1'b0) begin $display("FAIL even_release: got %b want 0", out_valid); bad++; end
    endtask

    task automatic test_odd_len7();
        cfg_data_bits = 5'd7; cfg_parity = 3'b001; cfg_stop2 = 0; out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            set_frame(8'hFF, 0, k[0], 2'b01); step(); frm_valid = 0;
            cur = sb_q.pop_front();
            total++; if ({out_valid, out_err, out_data} !== {1'b1, cur}) begin $display("FAIL odd7_frame%0d: got %b/%b/%h want 1/%b/%h", k, out_valid, out_err, out_data, cur[11:8], cur[7:0]); bad++; end
            total++; if (parity_cnt !== m_pc) begin $display("FAIL odd7_pcnt%0d: got %0d want %0d", k, parity_cnt, m_pc); bad++; end
        end
        out_ready = 0;
        drain();
    endtask

    task automatic test_stop_break();
        cfg_data_bits = 5'd8; cfg_parity = 3'b000; out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            cfg_stop2 = k[0];
            set_frame(8'h00, 0, 0, (k == 0) ? 2'b00 : 2'b01); step(); frm_valid = 0;
            cur = sb_q.pop_front();
            total++; if ({out_valid, out_err, out_data} !== {1'b1, cur}) begin $display("FAIL stopbrk_frame%0d: got %b/%b/%h want 1/%b/%h", k, out_valid, out_err, out_data, cur[11:8], cur[7:0]); bad++; end
            total++; if (framing_cnt !== m_fc) begin $display("FAIL stopbrk_fcnt%0d: got %0d want %0d", k, framing_cnt, m_fc); bad++; end
        end
        out_ready = 0; cfg_stop2 = 0;
        drain();
    endtask

    task automatic test_overrun();
        cfg_data_bits = 5'd8; cfg_parity = 3'b000; cfg_stop2 = 0; out_ready = 0;
        set_frame(8'h11, 0, 0, 2'b01); step(); frm_valid = 0;
        cur = sb_q.pop_front();
        total++; if ({out_valid, out_data} !== {1'b1, cur[7:0]}) begin $display("FAIL ovr_first: got %b/%h want 1/%h", out_valid, out_data, cur[7:0]); bad++; end
        set_frame(8'h22, 1, 0, 2'b00); step(); frm_valid = 0;
        total++; if ({out_valid, out_err, out_data} !== {1'b1, cur}) begin $display("FAIL ovr_held: got %b/%b/%h want 1/%b/%h", out_valid, out_err, out_data, cur[11:8], cur[7:0]); bad++; end
        total++; if (overrun !== m_ovr || framing_cnt !== m_fc) begin $display("FAIL ovr_flag: got ovr=%b fc=%0d want %b/%0d", overrun, framing_cnt, m_ovr, m_fc); bad++; end
        out_ready = 1;
        set_frame(8'h33, 0, 0, 2'b01); step(); frm_valid = 0; out_ready = 0;
        cur = sb_q.pop_front();
        total++; if ({out_valid, out_data} !== {1'b1, cur[7:0]}) begin $display("FAIL ovr_replace: got %b/%h want 1/%h", out_valid, out_data, cur[7:0]); bad++; end
        clr_stats = 1; step(); clr_stats = 0;
        total++; if (overrun !== m_ovr || overrun !== 1'b0) begin $display("FAIL ovr_clear: got %b want 0", overrun); bad++; end
        drain();
    endtask

    task automatic test_back_to_back();
        cfg_data_bits = 5'd8; cfg_parity = 3'b000; cfg_stop2 = 0;
        clr_stats = 1; step(); clr_stats = 0;
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            set_frame(8'h40 + 8'(k), 1, 0, 2'b01); step();
            cur = sb_q.pop_front();
            total++; if ({out_valid, out_err, out_data} !== {1'b1, cur}) begin $display("FAIL b2b_frame%0d: got %b/%b/%h want 1/%b/%h", k, out_valid, out_err, out_data, cur[11:8], cur[7:0]); bad++; end
        end
        frm_valid = 0;
        total++; if (framing_cnt !== m_fc || framing_cnt !== 2'd3) begin $display("FAIL b2b_sat: got %0d want 3", framing_cnt); bad++; end
        set_frame(8'h55, 1, 0, 2'b01); clr_stats = 1; step(); clr_stats = 0; frm_valid = 0;
        cur = sb_q.pop_front();
        total++; if (framing_cnt !== m_fc || framing_cnt !== 2'd1) begin $display("FAIL b2b_clr_inc: got %0d want 1", framing_cnt); bad++; end
        out_ready = 0;
        drain();
    endtask

    task automatic test_async_reset();
        cfg_data_bits = 5'd8; cfg_parity = 3'b010; cfg_stop2 = 0; out_ready = 0;
        set_frame(8'h01, 1, 0, 2'b01); step(); frm_valid = 0;
        cur = sb_q.pop_front();
        set_frame(8'h02, 0, 0, 2'b01); step(); frm_valid = 0;
        total++; if ({out_valid, overrun, parity_cnt, framing_cnt} !== {1'b1, m_ovr, m_pc, m_fc}) begin $display("FAIL arst_pre: got v=%b ovr=%b pc=%0d fc=%0d want 1/%b/%0d/%0d", out_valid, overrun, parity_cnt, framing_cnt, m_ovr, m_pc, m_fc); bad++; end
        reset_n = 1'b0;
        #2;
        mv = 0; m_pc = '0; m_fc = '0; m_ovr = 0; sb_q.delete();
        total++; if (out_valid !== 1'b0 || out_err !== 4'h0 || out_data !== 8'h00) begin $display("FAIL arst_frame: got %b/%b/%h want 0/0000/00", out_valid, out_err, out_data); bad++; end
        total++; if (overrun !== 1'b0 || parity_cnt !== '0 || framing_cnt !== '0) begin $display("FAIL arst_stats: got ovr=%b pc=%0d fc=%0d want 0/0/0", overrun, parity_cnt, framing_cnt); bad++; end
        #2;
        reset_n = 1'b1;
        set_frame(8'hA5, 0, 0, 2'b01); step(); frm_valid = 0;
        cur = sb_q.pop_front();
        total++; if ({out_valid, out_err, out_data} !== {1'b1, cur}) begin $display("FAIL arst_after: got %b/%b/%h want 1/%b/%h", out_valid, out_err, out_data, cur[11:8], cur[7:0]); bad++; end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            cfg_data_bits = 5'($urandom_range(0, 31));
            cfg_parity    = 3'($urandom_range(0, 7));
            cfg_stop2     = 1'($urandom_range(0, 1));
            out_ready     = 1'($urandom_range(0, 1));
            clr_stats     = ($urandom_range(0, 7) == 0);
            frm_data      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            frm_start     = ($urandom_range(0, 3) == 0);
            frm_parity    = 1'($urandom_range(0, 1));
            frm_stop      = 2'($urandom_range(0, 3));
            frm_valid     = ($urandom_range(0, 2) != 0);
            step();
            frm_valid = 0; clr_stats = 0;
            if (sb_q.size() != 0) cur = sb_q.pop_front();
            total++; if (out_valid !== mv || (mv && {out_err, out_data} !== cur)) begin $display("FAIL rand_out%0d: got %b/%b/%h want %b/%b/%h", k, out_valid, out_err, out_data, mv, cur[11:8], cur[7:0]); bad++; end
            total++; if ({overrun, parity_cnt, framing_cnt} !== {m_ovr, m_pc, m_fc}) begin $display("FAIL rand_stats%0d: got ovr=%b pc=%0d fc=%0d want %b/%0d/%0d", k, overrun, parity_cnt, framing_cnt, m_ovr, m_pc, m_fc); bad++; end
        end
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_len7();
        test_stop_break();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
